siren_expediente_ctrl: RTL and testbench
========================================

Name: siren_expediente_ctrl

Overview:
- Sequential, parametrised successor to the combinational end-of-shift siren.
- Evaluates the shift-end condition over NLINES production lines, debounces it, and drives a timed blast pattern (pulsed) or a latched tone (continuous) on the siren output.
- Supports operator silence (ack), re-arm on condition release, and a saturating event counter for the board display (LED/SEG).
- Sits in top between the SWI-mapped inputs and the LED/SEG outputs.

Parameters:
NLINES, 4, number of production lines monitored
DEB_CYCLES, 3, consecutive cycles cond must hold before sounding (>=1)
BLAST_ON, 2, cycles siren high per blast in pulsed mode (>=1)
BLAST_OFF, 1, cycles siren low between blasts (>=1)
NBLASTS, 3, blasts per event in pulsed mode (>=1)
CNT_W, 8, width of event counter

Ports:
clk_2  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
noite  in  1  night-shift flag
sexta  in  1  Friday flag
producao  in  1  weekly production target reached
line_stop  in  NLINES  per-line stopped flag
line_en  in  NLINES  per-line monitor enable mask
ack  in  1  operator silence request, level-sampled
mode_cont  in  1  0 = pulsed pattern, 1 = continuous tone
siren  out  1  siren drive, registered
busy  out  1  high in QUAL, ON, OFF
event_cnt  out  CNT_W  count of qualified events, saturating
state_o  out  3  current state encoding, for debug/LCD

Behaviour:
- cond (combinational) = all_stopped && (noite || (sexta && producao)).
- all_stopped = (line_en != 0) && ((line_stop & line_en) == line_en). Disabled lines are ignored; an all-zero mask never fires.
- All outputs are registered. Reset (async, rst_n=0): state=IDLE, siren=0, busy=0, event_cnt=0, all timers 0. Reset mid-operation aborts immediately; no output glitches high.
- States: IDLE=0, QUAL=1, ON=2, OFF=3, HOLD=4.
- IDLE:
  - cond=1 and DEB_CYCLES=1: go to ON.
  - cond=1 otherwise: go to QUAL with deb=1.
- QUAL:
  - cond=0: go to IDLE and clear deb.
  - cond=1 and deb==DEB_CYCLES-1: go to ON.
  - Otherwise deb++.
  - cond must therefore be sampled high on DEB_CYCLES consecutive edges; siren rises after the last of them.
- Entry into ON from IDLE/QUAL:
  - event_cnt increments by 1, holding at 2^CNT_W-1.
  - mode_cont is latched as mode_q; later changes are ignored until the next event.
  - blast=0, tmr=0.
- ON, pulsed: siren=1.
  - Stays BLAST_ON cycles.
  - Then, if blast==NBLASTS-1, go to HOLD (no trailing gap).
  - Else go to OFF and blast++.
- OFF: siren=0 for BLAST_OFF cycles, then ON.
- ON, continuous: siren=1 indefinitely; the timer is ignored.
- Any of ON/OFF:
  - cond=0: go to IDLE; siren low on the next cycle.
  - ack=1 (cond=1): go to HOLD.
  - cond=0 takes priority over ack.
- HOLD:
  - siren=0, busy=0.
  - Remains while cond=1, ignoring ack.
  - cond=0: go to IDLE (re-arm). A new event requires cond to drop and re-qualify.
- ack in IDLE/QUAL has no effect.

Decomposition:
- Package siren_pkg holds:
  - state enum siren_state_t (3-bit, values above);
  - localparams for the timer width, $clog2(max(DEB_CYCLES, BLAST_ON, BLAST_OFF)+1), and the blast width, $clog2(NBLASTS+1).
- One sub-module, siren_timer: a loadable down-counter with a done flag. It is reused for debounce and ON/OFF durations.
- The FSM, cond logic and event counter live in siren_expediente_ctrl.

Test Plan:
1. Defaults, line_en=4'hF, line_stop=4'hF, noite=1 held from edge e1 -> siren per cycle after e3..e10 = 1,1,0,1,1,0,1,1, then 0 (HOLD). busy=0 after e11; event_cnt=1; no second event while cond stays 1.
2. Glitch: cond high for 2 edges then low -> siren never rises, state back to IDLE, event_cnt=0. line_en=0 with all stops and noite=1 -> no event.
3. Friday path, line_en=4'b0111, line_stop=4'b0111, sexta=1, producao=1, noite=0 -> event fires (line 3 ignored). Then producao=0 mid-pattern -> siren 0 next cycle, IDLE, event_cnt=1. Re-raise producao -> second event, event_cnt=2.
4. ack=1 in the second ON of scenario 1 -> HOLD next cycle, siren 0. Release cond then reassert -> full pattern again; event_cnt=2.
5. mode_cont=1 at qualification -> siren stays 1 for 50 cycles. Toggling mode_cont to 0 mid-tone has no effect. ack -> siren 0 next cycle.
6. rst_n pulsed low mid-OFF -> siren, busy, event_cnt 0 immediately, without a clock edge. Separately, CNT_W=2 with 5 events -> event_cnt saturates at 3.

Source files
------------

// File: rtl/siren_pkg.sv
// Shared state encoding and width helpers for the shift-end siren controller.
// Widths depend on the instance parameters, so the helpers are called from the top.
package siren_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_QUAL = 3'd1,
        S_ON   = 3'd2,
        S_OFF  = 3'd3,
        S_HOLD = 3'd4
    } siren_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int tmr_width(input int deb, input int bon, input int boff);
        return $clog2(max3(deb, bon, boff) + 1);
    endfunction

    function automatic int blast_width(input int nblasts);
        return $clog2(nblasts + 1);
    endfunction

    localparam int DEF_DEB_CYCLES = 3;
    localparam int DEF_BLAST_ON   = 2;
    localparam int DEF_BLAST_OFF  = 1;
    localparam int DEF_NBLASTS    = 3;
    localparam int TMR_W   = tmr_width(DEF_DEB_CYCLES, DEF_BLAST_ON, DEF_BLAST_OFF);
    localparam int BLAST_W = blast_width(DEF_NBLASTS);

endpackage

// File: rtl/siren_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Load takes effect on the next edge and wins over decrement; no flow control.
module siren_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/siren_expediente_ctrl.sv
// Shift-end siren: debounces the stop condition, then plays a blast pattern or a continuous tone.
// All outputs registered; siren follows the state reached at each edge, no handshake on inputs.
module siren_expediente_ctrl
    import siren_pkg::*;
#(
    parameter int NLINES     = 4,
    parameter int DEB_CYCLES = 3,
    parameter int BLAST_ON   = 2,
    parameter int BLAST_OFF  = 1,
    parameter int NBLASTS    = 3,
    parameter int CNT_W      = 8
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic              noite,
    input  logic              sexta,
    input  logic              producao,
    input  logic [NLINES-1:0] line_stop,
    input  logic [NLINES-1:0] line_en,
    input  logic              ack,
    input  logic              mode_cont,
    output logic              siren,
    output logic              busy,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [2:0]        state_o
);

    localparam int TW = tmr_width(DEB_CYCLES, BLAST_ON, BLAST_OFF);
    localparam int BW = blast_width(NBLASTS);

    // The timer counts down to zero, so each duration loads its length minus one;
    // the debounce loads one less again because the IDLE edge already counted.
    localparam logic [TW-1:0] DEB_LOAD  = TW'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);
    localparam logic [TW-1:0] ON_LOAD   = TW'(BLAST_ON - 1);
    localparam logic [TW-1:0] OFF_LOAD  = TW'(BLAST_OFF - 1);
    localparam logic [BW-1:0] LAST_BLST = BW'(NBLASTS - 1);

    logic all_stopped;
    logic cond;

    assign all_stopped = (line_en != '0) && ((line_stop & line_en) == line_en);
    assign cond        = all_stopped && (noite || (sexta && producao));

    siren_state_t    state_q, state_d;
    logic [BW-1:0]   blast_q, blast_d;
    logic            mode_q, mode_d;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic            siren_q, siren_d;
    logic            busy_q, busy_d;
    logic            enter_on;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_dec;
    logic            tmr_done;

    siren_timer #(.W(TW)) u_timer (
        .clk      (clk_2),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        blast_d     = blast_q;
        mode_d      = mode_q;
        event_cnt_d = event_cnt_q;
        enter_on    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cond) begin
                    if (DEB_CYCLES == 1) begin
                        enter_on = 1'b1;
                    end else begin
                        state_d  = S_QUAL;
                        tmr_load = 1'b1;
                        tmr_val  = DEB_LOAD;
                    end
                end
            end
            S_QUAL: begin
                if (!cond)         state_d  = S_IDLE;
                else if (tmr_done) enter_on = 1'b1;
                else               tmr_dec  = 1'b1;
            end
            S_ON: begin
                if (!cond) begin
                    state_d = S_IDLE;
                end else if (ack) begin
                    state_d = S_HOLD;
                end else if (!mode_q) begin
                    if (!tmr_done) begin
                        tmr_dec = 1'b1;
                    end else if (blast_q == LAST_BLST) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d  = S_OFF;
                        blast_d  = blast_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LOAD;
                    end
                end
            end
            S_OFF: begin
                if (!cond) begin
                    state_d = S_IDLE;
                end else if (ack) begin
                    state_d = S_HOLD;
                end else if (tmr_done) begin
                    state_d  = S_ON;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_HOLD: begin
                if (!cond) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Mode is captured once per event so a mid-tone toggle cannot change the pattern.
        if (enter_on) begin
            state_d  = S_ON;
            mode_d   = mode_cont;
            blast_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
            if (event_cnt_q != '1) event_cnt_d = event_cnt_q + 1'b1;
        end

        siren_d = (state_d == S_ON);
        busy_d  = (state_d == S_QUAL) || (state_d == S_ON) || (state_d == S_OFF);
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            blast_q     <= '0;
            mode_q      <= 1'b0;
            event_cnt_q <= '0;
            siren_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blast_q     <= blast_d;
            mode_q      <= mode_d;
            event_cnt_q <= event_cnt_d;
            siren_q     <= siren_d;
            busy_q      <= busy_d;
        end
    end

    assign siren     = siren_q;
    assign busy      = busy_q;
    assign event_cnt = event_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_siren_expediente_ctrl.sv
// Bench for the shift-end siren: expected siren/busy pairs are queued per scenario and popped each cycle.
module tb_siren_expediente_ctrl;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       noite, sexta, producao, ack, mode_cont;
    logic [3:0] line_stop, line_en;
    logic       siren, busy, siren2, busy2;
    logic [7:0] event_cnt;
    logic [1:0] event_cnt2;
    logic [2:0] state_o, state2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    always #5 clk_2 = ~clk_2;

    siren_expediente_ctrl dut (
        .clk_2(clk_2), .rst_n(rst_n), .noite(noite), .sexta(sexta), .producao(producao),
        .line_stop(line_stop), .line_en(line_en), .ack(ack), .mode_cont(mode_cont),
        .siren(siren), .busy(busy), .event_cnt(event_cnt), .state_o(state_o)
    );

    siren_expediente_ctrl #(.CNT_W(2)) dut_sat (
        .clk_2(clk_2), .rst_n(rst_n), .noite(noite), .sexta(sexta), .producao(producao),
        .line_stop(line_stop), .line_en(line_en), .ack(ack), .mode_cont(mode_cont),
        .siren(siren2), .busy(busy2), .event_cnt(event_cnt2), .state_o(state2)
    );

    task automatic tick;
        @(posedge clk_2);
        #1;
    endtask

    task automatic clear_inputs;
        noite = 0; sexta = 0; producao = 0; ack = 0; mode_cont = 0;
        line_stop = 4'h0; line_en = 4'h0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    // Expected {siren,busy} after each edge of a full default pulsed event from IDLE.
    task automatic push_pattern(input int n_edges);
        logic [10:0] sir;
        logic [10:0] bsy;
        sir = 11'b00110110110;
        bsy = 11'b11111111110;
        for (int i = 10; i > 10 - n_edges; i--) exp_q.push_back({sir[i], bsy[i]});
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        #3;
        n_checks++;
        if ({siren, busy, event_cnt, state_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got siren=%b busy=%b cnt=%0d state=%0d, want all 0",
                     siren, busy, event_cnt, state_o);
        end
        rst_n = 1;
    endtask

    task automatic test_pulsed_pattern;
        logic [1:0] e;
        line_en = 4'hF; line_stop = 4'hF; noite = 1;
        push_pattern(11);
        for (int k = 1; exp_q.size() > 0; k++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({siren, busy} !== e) begin
                n_fail++;
                $display("FAIL pulsed_edge%0d: siren,busy=%b want %b", k, {siren, busy}, e);
            end
        end
        n_checks++;
        if (event_cnt !== 8'd1 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL pulsed_end: cnt=%0d state=%0d want cnt=1 state=4", event_cnt, state_o);
        end
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (siren !== 1'b0 || event_cnt !== 8'd1 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL hold_no_rearm: siren=%b cnt=%0d state=%0d want 0/1/4", siren, event_cnt, state_o);
        end
    endtask

    task automatic test_glitch;
        do_reset();
        line_en = 4'hF; line_stop = 4'hF; noite = 1;
        tick(); tick();
        noite = 0;
        tick();
        n_checks++;
        if (siren !== 1'b0 || state_o !== 3'd0 || event_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch: siren=%b state=%0d cnt=%0d want 0/0/0", siren, state_o, event_cnt);
        end
        line_en = 4'h0; noite = 1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (state_o !== 3'd0 || event_cnt !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_mask: state=%0d cnt=%0d busy=%b want 0/0/0", state_o, event_cnt, busy);
        end
    endtask

    task automatic test_friday;
        logic [1:0] e;
        do_reset();
        line_en = 4'b0111; line_stop = 4'b0111; sexta = 1; producao = 1;
        push_pattern(6);
        for (int k = 1; exp_q.size() > 0; k++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({siren, busy} !== e) begin
                n_fail++;
                $display("FAIL friday_edge%0d: siren,busy=%b want %b", k, {siren, busy}, e);
            end
        end
        producao = 0;
        tick();
        n_checks++;
        if (siren !== 1'b0 || state_o !== 3'd0 || event_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL friday_drop: siren=%b state=%0d cnt=%0d want 0/0/1", siren, state_o, event_cnt);
        end
        producao = 1;
        tick(); tick(); tick();
        n_checks++;
        if (siren !== 1'b1 || state_o !== 3'd2 || event_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL friday_second: siren=%b state=%0d cnt=%0d want 1/2/2", siren, state_o, event_cnt);
        end
    endtask

    task automatic test_ack;
        logic [1:0] e;
        do_reset();
        line_en = 4'hF; line_stop = 4'hF; noite = 1;
        push_pattern(6);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({siren, busy} !== e) begin
                n_fail++;
                $display("FAIL ack_pre: siren,busy=%b want %b", {siren, busy}, e);
            end
        end
        ack = 1;
        tick();
        n_checks++;
        if (siren !== 1'b0 || busy !== 1'b0 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL ack_hold: siren=%b busy=%b state=%0d want 0/0/4", siren, busy, state_o);
        end
        tick(); tick();
        ack = 0;
        tick();
        n_checks++;
        if (state_o !== 3'd4 || siren !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_stay: state=%0d siren=%b want 4/0", state_o, siren);
        end
        noite = 0;
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL ack_rearm: state=%0d want 0", state_o);
        end
        noite = 1;
        push_pattern(11);
        for (int k = 1; exp_q.size() > 0; k++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({siren, busy} !== e) begin
                n_fail++;
                $display("FAIL ack_repeat_edge%0d: siren,busy=%b want %b", k, {siren, busy}, e);
            end
        end
        n_checks++;
        if (event_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ack_count: cnt=%0d want 2", event_cnt);
        end
    endtask

    task automatic test_continuous;
        do_reset();
        line_en = 4'hF; line_stop = 4'hF; noite = 1; mode_cont = 1;
        tick(); tick(); tick();
        for (int k = 0; k < 50; k++) begin
            if (k == 10) mode_cont = 0;
            n_checks++;
            if (siren !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cont_tone_cycle%0d: siren=%b busy=%b want 1/1", k, siren, busy);
            end
            tick();
        end
        ack = 1;
        tick();
        n_checks++;
        if (siren !== 1'b0 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL cont_ack: siren=%b state=%0d want 0/4", siren, state_o);
        end
        ack = 0;
    endtask

    task automatic test_reset_and_saturation;
        logic [1:0] e;
        int exp_sat;
        do_reset();
        line_en = 4'hF; line_stop = 4'hF; noite = 1;
        push_pattern(5);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({siren, busy} !== e) begin
                n_fail++;
                $display("FAIL pre_reset: siren,busy=%b want %b", {siren, busy}, e);
            end
        end
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if ({siren, busy, event_cnt, state_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: siren=%b busy=%b cnt=%0d state=%0d want all 0",
                     siren, busy, event_cnt, state_o);
        end
        #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            noite = 1;
            tick(); tick(); tick();
            noite = 0;
            tick();
            exp_sat = (i + 1 > 3) ? 3 : i + 1;
            n_checks++;
            if (event_cnt !== 8'(i + 1) || event_cnt2 !== 2'(exp_sat)) begin
                n_fail++;
                $display("FAIL saturate_ev%0d: cnt=%0d cnt2w=%0d want %0d/%0d",
                         i + 1, event_cnt, event_cnt2, i + 1, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulsed_pattern();
        test_glitch();
        test_friday();
        test_ack();
        test_continuous();
        test_reset_and_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
